mdu_seq: RTL

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq_pkg.sv | 38 +++
 rtl/mdu_divider.sv | 52 +++++
 rtl/mdu_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared MDU definitions: operation class (mdu_mod) constants, mode codes and FSM states.
// Imported by the multi-cycle MDU and its divider.
package mdu_seq_pkg;

  // Operation class lives in mode[2:1]; mode[0] selects unsigned for mul/div.
  localparam logic [1:0] MDU_MOD_MUL  = 2'b00;
  localparam logic [1:0] MDU_MOD_DIV  = 2'b01;
  localparam logic [1:0] MDU_MOD_MOVE = 2'b10;

  typedef enum logic [2:0] {
    MODE_MULT  = 3'b000,
    MODE_MULTU = 3'b001,
    MODE_DIV   = 3'b010,
    MODE_DIVU  = 3'b011,
    MODE_MTHI  = 3'b100,
    MODE_MTLO  = 3'b101,
    MODE_NONE  = 3'b111
  } mdu_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  function automatic logic is_mul_mode(input logic [2:0] m);
    return m[2:1] == MDU_MOD_MUL;
  endfunction

  function automatic logic is_div_mode(input logic [2:0] m);
    return m[2:1] == MDU_MOD_DIV;
  endfunction

  function automatic logic is_signed_mode(input logic [2:0] m);
    return ~m[0];
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Combinational signed/unsigned divider producing quotient and remainder.
// Signed results truncate toward zero; remainder follows the dividend's sign.
module mdu_divider
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;

  always_comb begin
    a_neg     = is_signed & dividend[WIDTH-1];
    b_neg     = is_signed & divisor[WIDTH-1];
    a_mag     = a_neg ? (-dividend) : dividend;
    b_mag     = b_neg ? (-divisor) : divisor;
    div_zero  = (divisor == '0);
    q_mag     = '0;
    r_mag     = '0;
    quotient  = '0;
    remainder = '0;

    if (div_zero) begin
      // Caller keeps HI/LO; outputs are don't-care but held at zero.
      quotient  = '0;
      remainder = '0;
    end else if (is_signed && dividend == MIN_VAL && divisor == '1) begin
      // Overflow case: the true quotient is not representable, MIN wraps to itself.
      quotient  = MIN_VAL;
      remainder = '0;
    end else begin
      q_mag     = a_mag / b_mag;
      r_mag     = a_mag % b_mag;
      quotient  = (a_neg ^ b_neg) ? (-q_mag) : q_mag;
      remainder = a_neg ? (-r_mag) : r_mag;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at the start edge and released after a fixed busy period.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             md_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output mdu_state_e       state_dbg
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_hi_q, res_lo_q;
  logic             res_keep_q;
  logic             done_q;

  logic             launch_mul, launch_div, complete, wr_hi, wr_lo;
  logic             sgn;
  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, product;
  logic [WIDTH-1:0] quotient, remainder;
  logic             div_zero;

  // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both modes.
  always_comb begin
    sgn       = is_signed_mode(mode);
    mul_a_ext = {{WIDTH{sgn & op_a[WIDTH-1]}}, op_a};
    mul_b_ext = {{WIDTH{sgn & op_b[WIDTH-1]}}, op_b};
    product   = mul_a_ext * mul_b_ext;
  end

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .dividend  (op_a),
    .divisor   (op_b),
    .is_signed (sgn),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    launch_mul = 1'b0;
    launch_div = 1'b0;
    complete   = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush) begin
          if (start && is_mul_mode(mode)) begin
            state_d    = ST_MUL;
            cnt_d      = CNT_MUL;
            launch_mul = 1'b1;
          end else if (start && is_div_mode(mode)) begin
            state_d    = ST_DIV;
            cnt_d      = CNT_DIV;
            launch_div = 1'b1;
          end else if (!start && mode == MODE_MTHI) begin
            wr_hi = 1'b1;
          end else if (!start && mode == MODE_MTLO) begin
            wr_lo = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        // Flush outranks completion so a cancelled result never lands.
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_ONE) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= complete;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      res_keep_q <= 1'b0;
    end else if (launch_mul) begin
      res_hi_q   <= product[2*WIDTH-1:WIDTH];
      res_lo_q   <= product[WIDTH-1:0];
      res_keep_q <= 1'b0;
    end else if (launch_div) begin
      res_hi_q   <= remainder;
      res_lo_q   <= quotient;
      res_keep_q <= div_zero;
    end
  end

  // A zero-divisor divide still completes, but leaves HI/LO untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (complete) begin
      if (!res_keep_q) begin
        hi <= res_hi_q;
        lo <= res_lo_q;
      end
    end else if (wr_hi) begin
      hi <= op_a;
    end else if (wr_lo) begin
      lo <= op_a;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign stall     = md_req & (busy | start);
  assign state_dbg = state_q;

endmodule
